// File: rtl/stack_cpu_pkg.sv
// Shared opcodes, ALU codes, FSM state encoding and control word for the stack CPU controller.
package stack_cpu_pkg;

  localparam int unsigned OPC_W = 3;
  localparam int unsigned ALU_W = 2;
  localparam int unsigned ST_W  = 4;

  localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OPC_W-1:0] OP_AND  = 3'b010;
  localparam logic [OPC_W-1:0] OP_NOT  = 3'b011;
  localparam logic [OPC_W-1:0] OP_PUSH = 3'b100;
  localparam logic [OPC_W-1:0] OP_POP  = 3'b101;
  localparam logic [OPC_W-1:0] OP_JMP  = 3'b110;
  localparam logic [OPC_W-1:0] OP_JZ   = 3'b111;

  localparam logic [ALU_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALU_W-1:0] ALU_AND = 2'b10;
  localparam logic [ALU_W-1:0] ALU_NOT = 2'b11;

  typedef enum logic [ST_W-1:0] {
    ST_INIT    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_POPA    = 4'd3,
    ST_POPB    = 4'd4,
    ST_EXEC    = 4'd5,
    ST_PUSHRES = 4'd6,
    ST_MEMRD   = 4'd7,
    ST_PUSHMEM = 4'd8,
    ST_POPST   = 4'd9,
    ST_MEMWR   = 4'd10,
    ST_JMP     = 4'd11,
    ST_JZTEST  = 4'd12,
    ST_JZBR    = 4'd13
  } state_e;

  typedef struct packed {
    logic             iord;
    logic             mtos;
    logic             src_a;
    logic             src_b;
    logic             pc_write;
    logic             pc_write_cond;
    logic             pc_src;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             ld_a;
    logic             ld_b;
    logic             push;
    logic             pop;
    logic             tos;
    logic [ALU_W-1:0] alu_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/stack_ctrl_outdec.sv
// Combinational decode of an FSM state into the datapath control word.
module stack_ctrl_outdec
  import stack_cpu_pkg::*;
(
  input  logic [ST_W-1:0]   state_i,
  input  logic [ALU_W-1:0]  alu_op_i,
  output logic [CTRL_W-1:0] ctrl_c_o
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (state_e'(state_i))
      ST_FETCH: begin
        c.mem_read = 1'b1;
        c.ir_write = 1'b1;
        c.src_a    = 1'b1;
        c.src_b    = 1'b1;
        c.pc_write = 1'b1;
      end
      ST_POPA, ST_POPST: begin
        c.tos  = 1'b1;
        c.ld_a = 1'b1;
        c.pop  = 1'b1;
      end
      ST_POPB: begin
        c.tos  = 1'b1;
        c.ld_b = 1'b1;
        c.pop  = 1'b1;
      end
      ST_EXEC:    c.alu_op = alu_op_i;
      ST_PUSHRES: c.push = 1'b1;
      ST_MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      ST_PUSHMEM: begin
        c.mtos = 1'b1;
        c.push = 1'b1;
      end
      ST_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      ST_JMP: begin
        c.pc_src   = 1'b1;
        c.pc_write = 1'b1;
      end
      ST_JZTEST: c.tos = 1'b1;
      ST_JZBR: begin
        c.pc_src        = 1'b1;
        c.pc_write_cond = 1'b1;
      end
      default: c = '0;
    endcase
  end

  assign ctrl_c_o = c;

endmodule

// File: rtl/stack_cpu_controller.sv
// Multi-cycle control FSM for the 8-bit stack CPU. Define STACK_CTRL_PERF_EN to add the
// retired-instruction counter (instr_count, CNT_W bits).
module stack_cpu_controller
  import stack_cpu_pkg::*;
`ifdef STACK_CTRL_PERF_EN
#(
  parameter int unsigned CNT_W = 16
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] Opcode,
  output logic       IorD,
  output logic       MtoS,
  output logic       srcA,
  output logic       srcB,
  output logic       PCwrite,
  output logic       PCwritecond,
  output logic       PCsrc,
  output logic       IRwrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       ldA,
  output logic       ldB,
  output logic       push,
  output logic       pop,
  output logic       tos,
  output logic [1:0] ALUOperation
`ifdef STACK_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_count
`endif
);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  ctrl_t               ctrl_s;

  // Strobes are decoded from the next state and registered, so they track state_q exactly.
  stack_ctrl_outdec u_outdec (
    .state_i  (state_d),
    .alu_op_i (Opcode[1:0]),
    .ctrl_c_o (ctrl_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = ST_INIT;
    case (state_q)
      ST_INIT:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (Opcode)
          OP_PUSH: state_d = ST_MEMRD;
          OP_POP:  state_d = ST_POPST;
          OP_JMP:  state_d = ST_JMP;
          OP_JZ:   state_d = ST_JZTEST;
          default: state_d = ST_POPA;
        endcase
      end
      ST_POPA:    state_d = (Opcode == OP_NOT) ? ST_EXEC : ST_POPB;
      ST_POPB:    state_d = ST_EXEC;
      ST_EXEC:    state_d = ST_PUSHRES;
      ST_PUSHRES: state_d = ST_FETCH;
      ST_MEMRD:   state_d = ST_PUSHMEM;
      ST_PUSHMEM: state_d = ST_FETCH;
      ST_POPST:   state_d = ST_MEMWR;
      ST_MEMWR:   state_d = ST_FETCH;
      ST_JMP:     state_d = ST_FETCH;
      ST_JZTEST:  state_d = ST_JZBR;
      ST_JZBR:    state_d = ST_FETCH;
      default:    state_d = ST_INIT;
    endcase
  end

  assign ctrl_s       = ctrl_t'(ctrl_q);
  assign IorD         = ctrl_s.iord;
  assign MtoS         = ctrl_s.mtos;
  assign srcA         = ctrl_s.src_a;
  assign srcB         = ctrl_s.src_b;
  assign PCwrite      = ctrl_s.pc_write;
  assign PCwritecond  = ctrl_s.pc_write_cond;
  assign PCsrc        = ctrl_s.pc_src;
  assign IRwrite      = ctrl_s.ir_write;
  assign MemRead      = ctrl_s.mem_read;
  assign MemWrite     = ctrl_s.mem_write;
  assign ldA          = ctrl_s.ld_a;
  assign ldB          = ctrl_s.ld_b;
  assign push         = ctrl_s.push;
  assign pop          = ctrl_s.pop;
  assign tos          = ctrl_s.tos;
  assign ALUOperation = ctrl_s.alu_op;

`ifdef STACK_CTRL_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // An instruction retires when FETCH is re-entered; the INIT->FETCH start-up does not count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == ST_FETCH && state_q != ST_INIT) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Directed scoreboard bench for stack_cpu_controller; define STACK_CTRL_PERF_EN to also check instr_count.
module tb_stack_cpu_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] Opcode = 3'b000;
  logic IorD, MtoS, srcA, srcB, PCwrite, PCwritecond, PCsrc, IRwrite;
  logic MemRead, MemWrite, ldA, ldB, push, pop, tos;
  logic [1:0] ALUOperation;
`ifdef STACK_CTRL_PERF_EN
  logic [15:0] instr_count;
`endif

  stack_cpu_controller dut (
    .clk          (clk),
    .rst          (rst),
    .Opcode       (Opcode),
    .IorD         (IorD),
    .MtoS         (MtoS),
    .srcA         (srcA),
    .srcB         (srcB),
    .PCwrite      (PCwrite),
    .PCwritecond  (PCwritecond),
    .PCsrc        (PCsrc),
    .IRwrite      (IRwrite),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .ldA          (ldA),
    .ldB          (ldB),
    .push         (push),
    .pop          (pop),
    .tos          (tos),
    .ALUOperation (ALUOperation)
`ifdef STACK_CTRL_PERF_EN
    ,
    .instr_count  (instr_count)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [16:0] B_IORD  = 17'h10000;
  localparam logic [16:0] B_MTOS  = 17'h08000;
  localparam logic [16:0] B_SRCA  = 17'h04000;
  localparam logic [16:0] B_SRCB  = 17'h02000;
  localparam logic [16:0] B_PCW   = 17'h01000;
  localparam logic [16:0] B_PCWC  = 17'h00800;
  localparam logic [16:0] B_PCSRC = 17'h00400;
  localparam logic [16:0] B_IRW   = 17'h00200;
  localparam logic [16:0] B_MRD   = 17'h00100;
  localparam logic [16:0] B_MWR   = 17'h00080;
  localparam logic [16:0] B_LDA   = 17'h00040;
  localparam logic [16:0] B_LDB   = 17'h00020;
  localparam logic [16:0] B_PUSH  = 17'h00010;
  localparam logic [16:0] B_POP   = 17'h00008;
  localparam logic [16:0] B_TOS   = 17'h00004;

  localparam logic [16:0] E_IDLE    = 17'h00000;
  localparam logic [16:0] E_FETCH   = B_MRD | B_IRW | B_SRCA | B_SRCB | B_PCW;
  localparam logic [16:0] E_POPA    = B_TOS | B_LDA | B_POP;
  localparam logic [16:0] E_POPB    = B_TOS | B_LDB | B_POP;
  localparam logic [16:0] E_PUSHRES = B_PUSH;
  localparam logic [16:0] E_MEMRD   = B_IORD | B_MRD;
  localparam logic [16:0] E_PUSHMEM = B_MTOS | B_PUSH;
  localparam logic [16:0] E_MEMWR   = B_IORD | B_MWR;
  localparam logic [16:0] E_JMP     = B_PCSRC | B_PCW;
  localparam logic [16:0] E_JZTEST  = B_TOS;
  localparam logic [16:0] E_JZBR    = B_PCSRC | B_PCWC;

  logic [16:0] obs;
  assign obs = {IorD, MtoS, srcA, srcB, PCwrite, PCwritecond, PCsrc, IRwrite,
                MemRead, MemWrite, ldA, ldB, push, pop, tos, ALUOperation};

  logic [16:0] exp_q[$];
  string       tag_q[$];
  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic expect_cw(input string tag, input logic [16:0] cw);
    exp_q.push_back(cw);
    tag_q.push_back(tag);
  endtask

  // One clock per queued expectation; every entry is checked one step after the rising edge.
  task automatic drain();
    logic [16:0] e;
    string t;
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, 32'(obs), 32'(e));
    end
  endtask

  task automatic check_count(input string tag);
`ifdef STACK_CTRL_PERF_EN
    check(tag, 32'(instr_count), 32'(exp_cnt));
`else
    if (tag.len() == 0) $display("no tag");
`endif
  endtask

  // Called while the DUT sits in FETCH; ends with the DUT back in FETCH.
  task automatic run_instr(input logic [2:0] op, input string name);
    Opcode = op;
    expect_cw({name, "_decode"}, E_IDLE);
    case (op)
      3'b000: begin
        expect_cw({name, "_popa"}, E_POPA);  expect_cw({name, "_popb"}, E_POPB);
        expect_cw({name, "_exec"}, 17'h00000); expect_cw({name, "_pushres"}, E_PUSHRES);
      end
      3'b001: begin
        expect_cw({name, "_popa"}, E_POPA);  expect_cw({name, "_popb"}, E_POPB);
        expect_cw({name, "_exec"}, 17'h00001); expect_cw({name, "_pushres"}, E_PUSHRES);
      end
      3'b010: begin
        expect_cw({name, "_popa"}, E_POPA);  expect_cw({name, "_popb"}, E_POPB);
        expect_cw({name, "_exec"}, 17'h00002); expect_cw({name, "_pushres"}, E_PUSHRES);
      end
      3'b011: begin
        expect_cw({name, "_popa"}, E_POPA);
        expect_cw({name, "_exec"}, 17'h00003); expect_cw({name, "_pushres"}, E_PUSHRES);
      end
      3'b100: begin
        expect_cw({name, "_memrd"}, E_MEMRD); expect_cw({name, "_pushmem"}, E_PUSHMEM);
      end
      3'b101: begin
        expect_cw({name, "_popst"}, E_POPA);  expect_cw({name, "_memwr"}, E_MEMWR);
      end
      3'b110: expect_cw({name, "_jmp"}, E_JMP);
      default: begin
        expect_cw({name, "_jztest"}, E_JZTEST); expect_cw({name, "_jzbr"}, E_JZBR);
      end
    endcase
    expect_cw({name, "_next_fetch"}, E_FETCH);
    drain();
    exp_cnt++;
    check_count({name, "_count"});
  endtask

  initial begin
    #12;
    check("reset_outputs", 32'(obs), 32'(E_IDLE));
    check_count("reset_count");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("init_after_release", 32'(obs), 32'(E_IDLE));
    expect_cw("first_fetch", E_FETCH);
    drain();
    check_count("first_fetch_count");

    run_instr(3'b000, "add");
    run_instr(3'b001, "sub");
    run_instr(3'b010, "and");
    run_instr(3'b011, "not");
    run_instr(3'b100, "push");
    run_instr(3'b101, "pop");
    run_instr(3'b111, "jz");
    run_instr(3'b110, "jmp");
    run_instr(3'b000, "add2");
    run_instr(3'b011, "not2");
    check_count("ten_instr_count");

    Opcode = 3'b001;
    expect_cw("abort_decode", E_IDLE);
    expect_cw("abort_popa", E_POPA);
    expect_cw("abort_popb", E_POPB);
    expect_cw("abort_exec", 17'h00001);
    drain();
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    check("rst_mid_exec", 32'(obs), 32'(E_IDLE));
    check_count("rst_mid_exec_count");
    @(posedge clk);
    #1;
    check("rst_held", 32'(obs), 32'(E_IDLE));
    @(negedge clk);
    rst = 1'b1;
    expect_cw("refetch", E_FETCH);
    drain();
    check_count("refetch_count");
    run_instr(3'b110, "jmp_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
